// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// The width localparams describe the default 8-bit, 10-clock configuration.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    PUSH   = 3'd5,
    BREAK  = 3'd6
  } rx_state_t;

  localparam int unsigned DEF_CLKS_PER_BIT = 10;
  localparam int unsigned DEF_DATA_BITS    = 8;
  localparam int unsigned TIMER_W          = $clog2(DEF_CLKS_PER_BIT);
  localparam int unsigned BITCNT_W         = $clog2(DEF_DATA_BITS);
  localparam int unsigned MAX_DATA_BITS    = 9;

  // Returns 1 when the data word plus the received parity bit disagree with the selected sense.
  function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                       input logic                     par_bit,
                                       input logic                     odd);
    return (^data) ^ par_bit ^ odd;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous show-ahead FIFO; head shows the oldest entry, or 0 when empty.
// A pop on a full FIFO frees the slot for a push on the same edge.
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int P_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [P_W-1:0]   wr_ptr;
  logic [P_W-1:0]   rd_ptr;
  logic [P_W:0]     cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (P_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = cnt;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst && do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with optional parity, false-start rejection,
// break recovery and a show-ahead receive FIFO.
//
// state  | meaning
// IDLE   | line idle, watching for a falling edge
// START  | confirming the start bit at its mid-point
// DATA   | sampling payload bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit
// PUSH   | one-cycle decision: store frame or flag error
// BREAK  | line stuck low after a framing error, wait for idle
module uart_rx_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          serial_in,
  input  logic                          data_read,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun_error,
  output logic                          framing_error,
  output logic                          parity_error
);

  localparam int T_W = $clog2(CLKS_PER_BIT);
  localparam int B_W = $clog2(DATA_BITS);
  localparam logic [T_W-1:0] T_MID  = T_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [T_W-1:0] T_END  = T_W'(CLKS_PER_BIT - 1);
  localparam logic [B_W-1:0] B_LAST = B_W'(DATA_BITS - 1);

  rx_state_t            state;
  rx_state_t            state_nxt;
  logic                 sync1;
  logic                 sync2;
  logic                 line_prev;
  logic [T_W-1:0]       timer;
  logic [B_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop_bit;
  logic                 perr;
  logic                 tick_mid;
  logic                 tick_bit;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;

  assign tick_mid   = (timer == T_MID);
  assign tick_bit   = (timer == T_END);
  assign perr       = (PARITY_EN != 0) &&
                      parity_calc(MAX_DATA_BITS'(shreg), par_bit, 1'(PARITY_ODD));
  assign push       = (state == PUSH) && stop_bit && !perr;
  assign pop        = data_read && !empty;
  assign data_ready = !empty;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (line_prev && !sync2) state_nxt = START;
      START:   if (tick_mid) state_nxt = sync2 ? IDLE : DATA;
      DATA:    if (tick_bit && bit_cnt == B_LAST) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (tick_bit) state_nxt = STOP;
      STOP:    if (tick_bit) state_nxt = PUSH;
      PUSH:    state_nxt = (!stop_bit && !sync2) ? BREAK : IDLE;
      BREAK:   if (sync2) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync1         <= 1'b1;
      sync2         <= 1'b1;
      line_prev     <= 1'b1;
      state         <= IDLE;
      timer         <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      stop_bit      <= 1'b0;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      sync1     <= serial_in;
      sync2     <= sync1;
      line_prev <= sync2;
      state     <= state_nxt;

      // Every state change restarts the bit timer, so each phase counts from its own entry.
      if (state != state_nxt || tick_bit) timer <= '0;
      else                                timer <= timer + 1'b1;

      if (state == START)                bit_cnt <= '0;
      else if (state == DATA && tick_bit) bit_cnt <= bit_cnt + 1'b1;

      if (state == DATA && tick_bit)   shreg    <= {sync2, shreg[DATA_BITS-1:1]};
      if (state == PARITY && tick_bit) par_bit  <= sync2;
      if (state == STOP && tick_bit)   stop_bit <= sync2;

      if (state == PUSH) begin
        framing_error <= !stop_bit;
        parity_error  <= perr;
      end

      if (push && full && !pop) overrun_error <= 1'b1;
      else if (pop)             overrun_error <= 1'b0;
    end
  end

  rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push),
    .pop   (pop),
    .din   (shreg),
    .full  (full),
    .empty (empty),
    .count (fifo_count),
    .head  (rx_data)
  );

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E1, 5N1 at 16 clk/bit)
// checked against a queue model of the receive FIFO and frame rules.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       ser [3];
  logic       rd  [3];
  logic       rdy [3];
  logic       ovr [3];
  logic       fe  [3];
  logic       pe  [3];
  logic [2:0] cnt [3];
  logic [8:0] dat [3];
  logic [7:0] dat8;
  logic [7:0] datp;
  logic [4:0] dat5;

  int checks = 0;
  int errors = 0;
  bit hist [256];
  int cpb_of [3] = '{10, 10, 16};
  int nb_of  [3] = '{8, 8, 5};
  int par_of [3] = '{0, 1, 0};
  logic [8:0] exp_q [$];
  bit exp_ovr;

  assign dat[0] = {1'b0, dat8};
  assign dat[1] = {1'b0, datp};
  assign dat[2] = {4'b0, dat5};

  always #5 clk = ~clk;

  uart_rx_param u_8n1 (
    .clk(clk), .n_rst(n_rst), .serial_in(ser[0]), .data_read(rd[0]),
    .rx_data(dat8), .data_ready(rdy[0]), .fifo_count(cnt[0]),
    .overrun_error(ovr[0]), .framing_error(fe[0]), .parity_error(pe[0]));

  uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
    .clk(clk), .n_rst(n_rst), .serial_in(ser[1]), .data_read(rd[1]),
    .rx_data(datp), .data_ready(rdy[1]), .fifo_count(cnt[1]),
    .overrun_error(ovr[1]), .framing_error(fe[1]), .parity_error(pe[1]));

  uart_rx_param #(.DATA_BITS(5), .CLKS_PER_BIT(16)) u_5n1 (
    .clk(clk), .n_rst(n_rst), .serial_in(ser[2]), .data_read(rd[2]),
    .rx_data(dat5), .data_ready(rdy[2]), .fifo_count(cnt[2]),
    .overrun_error(ovr[2]), .framing_error(fe[2]), .parity_error(pe[2]));

  // Cycles from driving the start bit to data_ready: 2 sync + 1 detect + half bit
  // + remaining bit periods up to the stop mid-point + the PUSH cycle.
  function automatic int lat(input int w);
    return 4 + cpb_of[w]/2 + cpb_of[w]*(nb_of[w] + par_of[w] + 1);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read(input int w);
    @(negedge clk); rd[w] = 1'b1;
    @(negedge clk); rd[w] = 1'b0;
  endtask

  task automatic send(input int w, input logic [8:0] data, input bit stop_val,
                      input bit par_good, input int pop_at, input int abort_at);
    int cpb;
    bit bits [$];
    cpb = cpb_of[w];
    bits.push_back(1'b0);
    for (int i = 0; i < nb_of[w]; i++) bits.push_back(data[i]);
    if (par_of[w] != 0) begin
      bit p;
      p = ($countones(data) % 2) == 1;
      bits.push_back(par_good ? p : !p);
    end
    bits.push_back(stop_val);
    for (int k = 0; k < bits.size()*cpb; k++) begin
      @(negedge clk);
      hist[k] = rdy[w];
      if (k == abort_at) begin
        n_rst  = 1'b0;
        ser[w] = 1'b1;
        return;
      end
      if (k == pop_at) rd[w] = 1'b1;
      else if (k == pop_at + 1) rd[w] = 1'b0;
      ser[w] = bits[k/cpb];
    end
    rd[w] = 1'b0;
  endtask

  task automatic model_push(input logic [8:0] v, input bit popped);
    if (popped) void'(exp_q.pop_front());
    if (exp_q.size() < 4) exp_q.push_back(v);
    else exp_ovr = 1'b1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    for (int w = 0; w < 3; w++) begin ser[w] = 1'b1; rd[w] = 1'b0; end
    idle(3);
    for (int w = 0; w < 3; w++) begin
      checks++;
      if ({rdy[w], ovr[w], fe[w], pe[w], cnt[w], dat[w]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs inst=%0d got rdy=%b ovr=%b fe=%b pe=%b cnt=%0d dat=%h exp all 0",
                 w, rdy[w], ovr[w], fe[w], pe[w], cnt[w], dat[w]);
      end
    end
    n_rst = 1'b1;
    idle(5);
  endtask

  task automatic test_basic();
    int l;
    l = lat(0);
    send(0, 9'h0A5, 1'b1, 1'b1, -1, -1);
    checks++;
    if (hist[l-1] !== 1'b0 || hist[l] !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency got before=%b at=%b exp 0 then 1", hist[l-1], hist[l]);
    end
    checks++;
    if (dat[0] !== 9'h0A5 || cnt[0] !== 3'd1) begin
      errors++;
      $display("FAIL basic_data got dat=%h cnt=%0d exp a5 1", dat[0], cnt[0]);
    end
    do_read(0);
    checks++;
    if (cnt[0] !== 3'd0 || dat[0] !== 9'h0 || rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_pop got cnt=%0d dat=%h rdy=%b exp 0 0 0", cnt[0], dat[0], rdy[0]);
    end
    idle(10);
  endtask

  task automatic test_glitch();
    @(negedge clk); ser[0] = 1'b0;
    idle(3);
    ser[0] = 1'b1;
    idle(40);
    checks++;
    if (rdy[0] !== 1'b0 || fe[0] !== 1'b0 || pe[0] !== 1'b0 || cnt[0] !== 3'd0) begin
      errors++;
      $display("FAIL glitch got rdy=%b fe=%b pe=%b cnt=%0d exp all 0", rdy[0], fe[0], pe[0], cnt[0]);
    end
    send(0, 9'h03C, 1'b1, 1'b1, -1, -1);
    checks++;
    if (dat[0] !== 9'h03C || cnt[0] !== 3'd1) begin
      errors++;
      $display("FAIL glitch_recover got dat=%h cnt=%0d exp 3c 1", dat[0], cnt[0]);
    end
    do_read(0);
    idle(10);
  endtask

  task automatic test_parity();
    int l;
    l = lat(1);
    send(1, 9'h003, 1'b1, 1'b1, -1, -1);
    checks++;
    if (hist[l-1] !== 1'b0 || hist[l] !== 1'b1 || dat[1] !== 9'h003 || pe[1] !== 1'b0) begin
      errors++;
      $display("FAIL parity_good got rdy %b->%b dat=%h pe=%b exp 0->1 03 0",
               hist[l-1], hist[l], dat[1], pe[1]);
    end
    do_read(1);
    idle(10);
    send(1, 9'h003, 1'b1, 1'b0, -1, -1);
    checks++;
    if (pe[1] !== 1'b1 || cnt[1] !== 3'd0 || fe[1] !== 1'b0) begin
      errors++;
      $display("FAIL parity_bad got pe=%b cnt=%0d fe=%b exp 1 0 0", pe[1], cnt[1], fe[1]);
    end
    idle(10);
    for (int i = 0; i < 8; i++) begin
      logic [8:0] d;
      bit good;
      d    = 9'($urandom_range(0, 255));
      good = 1'($urandom_range(0, 1));
      send(1, d, 1'b1, good, -1, -1);
      checks++;
      if (pe[1] !== !good || cnt[1] !== (good ? 3'd1 : 3'd0) || dat[1] !== (good ? d : 9'h0)) begin
        errors++;
        $display("FAIL parity_rand d=%h good=%b got pe=%b cnt=%0d dat=%h", d, good, pe[1], cnt[1], dat[1]);
      end
      if (good) do_read(1);
      idle(5);
    end
  endtask

  task automatic test_break();
    send(0, 9'h05A, 1'b0, 1'b1, -1, -1);
    idle(300);
    checks++;
    if (fe[0] !== 1'b1 || pe[0] !== 1'b0 || cnt[0] !== 3'd0 || rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL break_hold got fe=%b pe=%b cnt=%0d rdy=%b exp 1 0 0 0", fe[0], pe[0], cnt[0], rdy[0]);
    end
    ser[0] = 1'b1;
    idle(20);
    send(0, 9'h011, 1'b1, 1'b1, -1, -1);
    checks++;
    if (dat[0] !== 9'h011 || fe[0] !== 1'b0 || cnt[0] !== 3'd1) begin
      errors++;
      $display("FAIL break_recover got dat=%h fe=%b cnt=%0d exp 11 0 1", dat[0], fe[0], cnt[0]);
    end
    do_read(0);
    idle(10);
  endtask

  task automatic test_overrun();
    exp_q.delete();
    exp_ovr = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send(0, 9'(i), 1'b1, 1'b1, -1, -1);
      model_push(9'(i), 1'b0);
      idle(5);
    end
    checks++;
    if (cnt[0] !== 3'(exp_q.size()) || ovr[0] !== exp_ovr || dat[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL overrun_full got cnt=%0d ovr=%b dat=%h exp %0d %b %h",
               cnt[0], ovr[0], dat[0], exp_q.size(), exp_ovr, exp_q[0]);
    end
    do_read(0);
    void'(exp_q.pop_front());
    exp_ovr = 1'b0;
    checks++;
    if (ovr[0] !== 1'b0 || cnt[0] !== 3'd3 || dat[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL overrun_clear got ovr=%b cnt=%0d dat=%h exp 0 3 %h", ovr[0], cnt[0], dat[0], exp_q[0]);
    end
    send(0, 9'h006, 1'b1, 1'b1, -1, -1);
    model_push(9'h006, 1'b0);
    idle(5);
    send(0, 9'h007, 1'b1, 1'b1, lat(0) - 1, -1);
    model_push(9'h007, 1'b1);
    idle(5);
    checks++;
    if (ovr[0] !== exp_ovr || cnt[0] !== 3'(exp_q.size()) || dat[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL push_pop_full got ovr=%b cnt=%0d dat=%h exp %b %0d %h",
               ovr[0], cnt[0], dat[0], exp_ovr, exp_q.size(), exp_q[0]);
    end
    while (exp_q.size() > 0) begin
      checks++;
      if (dat[0] !== exp_q[0]) begin
        errors++;
        $display("FAIL drain got dat=%h exp %h", dat[0], exp_q[0]);
      end
      do_read(0);
      void'(exp_q.pop_front());
    end
    checks++;
    if (cnt[0] !== 3'd0 || rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty got cnt=%0d rdy=%b exp 0 0", cnt[0], rdy[0]);
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    exp_ovr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      logic [8:0] d;
      int nr;
      nr = $urandom_range(0, 2);
      for (int r = 0; r < nr; r++) begin
        if (exp_q.size() > 0) begin
          checks++;
          if (dat[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL b2b_head got dat=%h exp %h", dat[0], exp_q[0]);
          end
          do_read(0);
          void'(exp_q.pop_front());
          exp_ovr = 1'b0;
        end
      end
      d = 9'($urandom_range(0, 255));
      send(0, d, 1'b1, 1'b1, -1, -1);
      model_push(d, 1'b0);
      idle(2);
      checks++;
      if (cnt[0] !== 3'(exp_q.size()) || ovr[0] !== exp_ovr || fe[0] !== 1'b0 ||
          dat[0] !== exp_q[0]) begin
        errors++;
        $display("FAIL b2b_state i=%0d got cnt=%0d ovr=%b fe=%b dat=%h exp %0d %b 0 %h",
                 i, cnt[0], ovr[0], fe[0], dat[0], exp_q.size(), exp_ovr, exp_q[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int l;
    l = lat(2);
    send(2, 9'h00A, 1'b1, 1'b1, -1, -1);
    checks++;
    if (dat[2] !== 9'h00A || cnt[2] !== 3'd1) begin
      errors++;
      $display("FAIL b5_first got dat=%h cnt=%0d exp 0a 1", dat[2], cnt[2]);
    end
    idle(5);
    send(2, 9'h01B, 1'b1, 1'b1, -1, cpb_of[2]*4 + cpb_of[2]/2);
    @(negedge clk);
    checks++;
    if ({rdy[2], ovr[2], fe[2], pe[2], cnt[2], dat[2]} !== '0) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b ovr=%b fe=%b pe=%b cnt=%0d dat=%h exp all 0",
               rdy[2], ovr[2], fe[2], pe[2], cnt[2], dat[2]);
    end
    n_rst = 1'b1;
    idle(200);
    checks++;
    if (rdy[2] !== 1'b0 || cnt[2] !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_nopush got rdy=%b cnt=%0d exp 0 0", rdy[2], cnt[2]);
    end
    send(2, 9'h015, 1'b1, 1'b1, -1, -1);
    checks++;
    if (hist[l-1] !== 1'b0 || hist[l] !== 1'b1 || dat[2] !== 9'h015 || cnt[2] !== 3'd1 || fe[2] !== 1'b0) begin
      errors++;
      $display("FAIL b5_after_reset got rdy %b->%b dat=%h cnt=%0d fe=%b exp 0->1 15 1 0",
               hist[l-1], hist[l], dat[2], cnt[2], fe[2]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_parity();
    test_break();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
